// File: rtl/mlp_pkg.sv
// Shared constants, network weights and FSM state type for the time-multiplexed
// 7-3-10 MLP inference sequencer.
package mlp_pkg;

  localparam int N_IN  = 7;
  localparam int N_HID = 3;
  localparam int N_OUT = 10;
  localparam int ACC_W = 14;
  localparam int H_W   = 9;
  localparam int CLS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HID  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Row = neuron, column = input / hidden index.
  localparam logic signed [6:0] W1 [N_HID][N_IN] = '{
    '{-7'sd3,  -7'sd5,  7'sd0,   7'sd4,  -7'sd1, 7'sd0,   -7'sd2},
    '{ 7'sd28,  7'sd19, -7'sd24, 7'sd15,  7'sd37, -7'sd37, 7'sd29},
    '{ 7'sd23,  7'sd36,  7'sd32, -7'sd9,  7'sd3,  -7'sd28, -7'sd30}
  };

  localparam logic signed [8:0] B1 [N_HID] = '{9'sd0, 9'sd5, 9'sd9};

  localparam logic signed [6:0] W2 [N_OUT][N_HID] = '{
    '{-7'sd6, -7'sd1,   7'sd23},
    '{ 7'sd5, -7'sd38,  7'sd32},
    '{ 7'sd5,  7'sd36, -7'sd30},
    '{ 7'sd3,  7'sd17,  7'sd8},
    '{-7'sd3, -7'sd27,  7'sd20},
    '{-7'sd4,  7'sd23, -7'sd29},
    '{ 7'sd3,  7'sd36, -7'sd48},
    '{-7'sd1, -7'sd17,  7'sd31},
    '{-7'sd6,  7'sd28, -7'sd13},
    '{-7'sd1,  7'sd7,   7'sd4}
  };

  localparam logic signed [9:0] B2 [N_OUT] = '{
    -10'sd180, -10'sd120, -10'sd280, -10'sd350, 10'sd380,
     10'sd360, -10'sd30,  -10'sd340, -10'sd90,  10'sd350
  };

endpackage

// File: rtl/mlp_infer_sequencer_if.sv
// Feature-in / class-out handshake bundle for the MLP inference sequencer.
interface mlp_infer_sequencer_if;
  import mlp_pkg::*;

  // Both channels are strict valid/ready: a transfer happens on a rising clk
  // edge where valid and ready are both high; valid never depends on ready.
  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN-1:0]         in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [CLS_W-1:0]        out_class;
  logic signed [ACC_W-1:0] out_score;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_class, out_score
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_score
  );
endinterface

// File: rtl/mlp_mac.sv
// Shared accumulator: loads a bias, adds one term per cycle, and exposes the
// running sum plus its ReLU'd hidden-activation view.
module mlp_mac
  import mlp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    load,
  input  logic                    add,
  input  logic signed [ACC_W-1:0] load_val,
  input  logic signed [ACC_W-1:0] term,
  output logic signed [ACC_W-1:0] sum,
  output logic [H_W-1:0]          relu
);

  logic signed [ACC_W-1:0] acc;

  assign sum  = acc + term;
  assign relu = sum[ACC_W-1] ? '0 : sum[H_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (ena) begin
      if (load)     acc <= load_val;
      else if (add) acc <= sum;
    end
  end

endmodule

// File: rtl/mlp_infer_sequencer.sv
// Time-multiplexed 7-3-10 MLP classifier: one MAC evaluates every term, an
// argmax tracker picks the winning class (lowest index wins ties).
module mlp_infer_sequencer
  import mlp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  mlp_infer_sequencer_if.slave  bus,
  output logic                  busy,
  output state_t                state_dbg
);

  state_t state, state_next;

  logic [N_IN-1:0]         x_q;
  logic [2:0]              i;
  logic [1:0]              j;
  logic [3:0]              k;
  logic [1:0]              j_inc;
  logic [3:0]              k_inc;
  logic [H_W-1:0]          h [N_HID];
  logic signed [ACC_W-1:0] best;
  logic [CLS_W-1:0]        best_k;
  logic [CLS_W-1:0]        cls_q;
  logic signed [ACC_W-1:0] score_q;

  logic                    last_i, last_j, last_k, upd;
  logic                    mac_load, mac_add;
  logic signed [ACC_W-1:0] load_val, term, hid_term, out_term, mac_sum;
  logic [H_W-1:0]          mac_relu;

  assign last_i = (i == 3'(N_IN - 1));
  assign last_j = (j == 2'(N_HID - 1));
  assign last_k = (k == 4'(N_OUT - 1));
  assign j_inc  = j + 2'd1;
  assign k_inc  = k + 4'd1;

  assign hid_term = x_q[i] ? ACC_W'(W1[j][i]) : '0;
  // Signed weight times unsigned activation; h is zero-extended before the cast.
  assign out_term = ACC_W'(W2[k][j]) * ACC_W'($signed({1'b0, h[j]}));
  assign upd      = (k == '0) || (mac_sum > best);

  mlp_mac u_mac (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .load     (mac_load),
    .add      (mac_add),
    .load_val (load_val),
    .term     (term),
    .sum      (mac_sum),
    .relu     (mac_relu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (ena) state <= state_next;
  end

  always_comb begin
    state_next = state;
    mac_load   = 1'b0;
    mac_add    = 1'b0;
    load_val   = '0;
    term       = '0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          mac_load   = 1'b1;
          load_val   = ACC_W'(B1[0]);
          state_next = HID;
        end
      end
      HID: begin
        term = hid_term;
        if (last_i) begin
          mac_load = 1'b1;
          if (last_j) begin
            load_val   = ACC_W'(B2[0]);
            state_next = OUT;
          end else begin
            load_val = ACC_W'(B1[j_inc]);
          end
        end else begin
          mac_add = 1'b1;
        end
      end
      OUT: begin
        term = out_term;
        if (last_j) begin
          if (last_k) begin
            state_next = DONE;
          end else begin
            mac_load = 1'b1;
            load_val = ACC_W'(B2[k_inc]);
          end
        end else begin
          mac_add = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      best    <= '0;
      best_k  <= '0;
      cls_q   <= '0;
      score_q <= '0;
      for (int n = 0; n < N_HID; n++) h[n] <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_q <= bus.in_data;
            i   <= '0;
            j   <= '0;
            k   <= '0;
          end
        end
        HID: begin
          if (last_i) begin
            h[j] <= mac_relu;
            i    <= '0;
            j    <= last_j ? 2'd0 : j_inc;
            k    <= '0;
          end else begin
            i <= i + 3'd1;
          end
        end
        OUT: begin
          if (last_j) begin
            j <= '0;
            k <= last_k ? 4'd0 : k_inc;
            if (upd) begin
              best   <= mac_sum;
              best_k <= k;
            end
            // The final class's sum is folded in directly so the result lands with DONE.
            if (last_k) begin
              cls_q   <= upd ? k : best_k;
              score_q <= upd ? mac_sum : best;
            end
          end else begin
            j <= j_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ena && (state == IDLE);
  assign bus.out_valid = ena && (state == DONE);
  assign bus.out_class = cls_q;
  assign bus.out_score = score_q;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_mlp_infer_sequencer.sv
// Directed and exhaustive checks of mlp_infer_sequencer against an independent
// parallel model of the 7-3-10 network.
module tb_mlp_infer_sequencer;
  import mlp_pkg::*;

  localparam int RES_W = CLS_W + ACC_W;

  logic   clk;
  logic   rst;
  logic   ena;
  logic   busy;
  state_t state_dbg;
  int     cyc;
  int     acc_cyc;
  int     n_checks;
  int     n_fail;
  int     lat;
  logic [CLS_W-1:0]        got_cls;
  logic signed [ACC_W-1:0] got_score;
  logic [RES_W-1:0]        exp_q[$];
  logic [RES_W-1:0]        e_hold;

  mlp_infer_sequencer_if bus ();

  mlp_infer_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent copy of the network tables
  int gw1 [3][7] = '{'{-3,-5,0,4,-1,0,-2}, '{28,19,-24,15,37,-37,29}, '{23,36,32,-9,3,-28,-30}};
  int gb1 [3] = '{0, 5, 9};
  int gw2 [10][3] = '{'{-6,-1,23}, '{5,-38,32}, '{5,36,-30}, '{3,17,8}, '{-3,-27,20},
                      '{-4,23,-29}, '{3,36,-48}, '{-1,-17,31}, '{-6,28,-13}, '{-1,7,4}};
  int gb2 [10] = '{-180,-120,-280,-350,380,360,-30,-340,-90,350};

  function automatic logic [RES_W-1:0] golden(input logic [N_IN-1:0] x);
    int a, s, bs, bk;
    int hh [3];
    for (int jj = 0; jj < 3; jj++) begin
      a = gb1[jj];
      for (int ii = 0; ii < 7; ii++) if (x[ii]) a += gw1[jj][ii];
      hh[jj] = (a < 0) ? 0 : a;
    end
    bs = 0;
    bk = 0;
    for (int kk = 0; kk < 10; kk++) begin
      s = gb2[kk];
      for (int jj = 0; jj < 3; jj++) s += gw2[kk][jj] * hh[jj];
      if (kk == 0 || s > bs) begin
        bs = s;
        bk = kk;
      end
    end
    return {CLS_W'(bk), ACC_W'(bs)};
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send(input logic [N_IN-1:0] x);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    exp_q.push_back(golden(x));
    @(posedge clk);
    @(negedge clk);
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = N_IN'($urandom_range(0, 127));
  endtask

  task automatic wait_out(output int latency);
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      bus.in_data = N_IN'($urandom_range(0, 127));
      n++;
    end
    latency = cyc - acc_cyc;
    check("out_valid_seen", bus.out_valid, 1);
  endtask

  // Scoreboard: pop and compare one result
  task automatic pop_check();
    logic [RES_W-1:0] e;
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e_hold    = e;
      got_cls   = bus.out_class;
      got_score = bus.out_score;
      check("out_class", bus.out_class, e[RES_W-1:ACC_W]);
      check("out_score", bus.out_score, $signed(e[ACC_W-1:0]));
    end
  endtask

  task automatic collect(input int exp_lat);
    wait_out(lat);
    check("latency", lat, exp_lat);
    pop_check();
    @(negedge clk);
    check("out_valid_after_hs", bus.out_valid, 0);
    check("in_ready_after_hs", bus.in_ready, 1);
    check("out_class_held", bus.out_class, e_hold[RES_W-1:ACC_W]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ena      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_class", bus.out_class, 0);
    check("rst_out_score", bus.out_score, 0);
    check("rst_state", state_dbg, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with known answers
    send(7'h00);
    collect(51);
    check("x00_class", got_cls, 4);
    check("x00_score", got_score, 425);
    send(7'h10);
    collect(51);
    check("x10_class", got_cls, 5);
    check("x10_score", got_score, 978);

    // Exhaustive sweep with random idle gaps
    for (int v = 0; v < 128; v++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(N_IN'(v));
      collect(51);
    end

    // Back-pressure in DONE
    bus.out_ready = 1'b0;
    send(7'h5A);
    wait_out(lat);
    check("bp_latency", lat, 51);
    e_hold = golden(7'h5A);
    bus.in_valid = 1'b1;
    bus.in_data  = 7'h3C;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_class", bus.out_class, e_hold[RES_W-1:ACC_W]);
      check("bp_score", bus.out_score, $signed(e_hold[ACC_W-1:0]));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    pop_check();
    @(negedge clk);
    check("bp_released", bus.out_valid, 0);
    repeat (5) @(negedge clk);
    check("bp_no_dup", bus.out_valid, 0);
    check("bp_idle", busy, 0);

    // Reset mid-inference
    send(7'h33);
    repeat (29) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_class", bus.out_class, 0);
    check("mid_rst_score", bus.out_score, 0);
    check("mid_rst_state", state_dbg, IDLE);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(7'h00);
    collect(51);
    check("post_rst_class", got_cls, 4);
    check("post_rst_score", got_score, 425);

    // Enable stalls mid-HID and in DONE
    send(7'h10);
    repeat (9) @(negedge clk);
    ena = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("ena_hid_out_valid", bus.out_valid, 0);
      check("ena_hid_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    ena = 1'b1;
    wait_out(lat);
    check("ena_latency", lat, 56);
    ena = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("ena_done_out_valid", bus.out_valid, 0);
      check("ena_done_busy", busy, 1);
      @(negedge clk);
    end
    ena = 1'b1;
    #1;
    check("ena_done_resume", bus.out_valid, 1);
    pop_check();
    check("ena_class", got_cls, 5);
    check("ena_score", got_score, 978);
    @(negedge clk);
    check("ena_after_hs", bus.out_valid, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_infer_sequencer.md
# mlp_infer_sequencer

- Time-multiplexed inference controller for the 7-input, 3-hidden-neuron (ReLU), 10-class classifier network. One shared multiply-accumulate unit evaluates the network term by term.
- Sits between the pin-level input register and the output register.
- Accepts one feature vector per valid/ready handshake and returns the winning class index and its logit on a valid/ready output.
- Trades latency (51 cycles) for area versus a fully parallel evaluation.

## Interface
- N_IN, 7, input feature bits
- N_HID, 3, hidden neurons
- N_OUT, 10, output classes
- ACC_W, 14, signed accumulator/logit width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  global enable; 0 freezes all state
- in_valid  in  1  feature vector offered
- in_ready  out  1  block can accept (IDLE and ena)
- in_data  in  N_IN  feature bits, bit i = input i
- out_valid  out  1  result available (DONE and ena)
- out_ready  in  1  consumer accepts result
- out_class  out  4  argmax class index, 0..9
- out_score  out  ACC_W  signed logit of winning class
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, HID, OUT, DONE.
- IDLE: in_ready=1 (when ena). On in_valid&in_ready:
  - latch in_data.
  - j=0, i=0, acc=B1[0] (sign-extended).
  - go to HID.
- HID: one term per cycle, acc += in_bit[i] ? W1[j][i] : 0.
  - On i=N_IN-1: h[j] = ReLU(acc) (negative -> 0), stored 9-bit unsigned.
  - Then acc=B1[j+1], i=0, j++.
  - After j=N_HID-1: k=0, j=0, acc=B2[0], go to OUT.
- OUT: one term per cycle, acc += W2[k][j]*h[j] (7b signed x 9b unsigned, into ACC_W).
  - On j=N_HID-1, compare final sum s against best:
    - k=0 or s > best: best=s, best_k=k. Strict >, so the lowest index wins ties.
    - Then acc=B2[k+1], k++.
  - After k=N_OUT-1: load out_class=best_k and out_score=best, go to DONE.
- DONE: out_valid=1. On out_ready go to IDLE. No new input is accepted in the same cycle.
- Arithmetic: two's complement, ACC_W-bit wrap, no saturation. The package weights guarantee no overflow.
- ena=0: state, counters, acc, h and outputs all hold. in_ready=0, out_valid=0.
- in_data is sampled only at acceptance. Changes on in_data during HID/OUT are ignored.
- out_class/out_score stay stable while out_valid=1. They hold their last value after the handshake until the next result.
- Reset values: state IDLE, in_ready=1 (if ena), out_valid=0, busy=0, out_class=0, out_score=0, acc/h/best cleared.
- Reset mid-operation aborts the inference. No partial result is ever presented.

## Timing
- Acceptance at edge T.
- HID terms at edges T+1..T+21 (N_IN*N_HID).
- OUT terms at edges T+22..T+51 (N_HID*N_OUT).
- out_valid high after edge T+51, so latency is 51 cycles with ena=1 throughout.
- Each ena=0 cycle adds exactly one cycle of latency.
- Output handshake at edge U: in_ready high after U. Earliest next acceptance is U+1.
- Minimum initiation interval: 53 cycles.

## Structure
- Package mlp_pkg holds:
  - N_IN/N_HID/N_OUT/ACC_W, H_W=9.
  - W1[3][7] and W2[10][3] 7-bit signed.
  - B1[3] 9-bit signed, B2[10] 10-bit signed.
  - state enum.
- Weight values (row = neuron):
  - W1 = {{-3,-5,0,4,-1,0,-2}, {28,19,-24,15,37,-37,29}, {23,36,32,-9,3,-28,-30}}
  - B1 = {0,5,9}
  - W2 = {{-6,-1,23}, {5,-38,32}, {5,36,-30}, {3,17,8}, {-3,-27,20}, {-4,23,-29}, {3,36,-48}, {-1,-17,31}, {-6,28,-13}, {-1,7,4}}
  - B2 = {-180,-120,-280,-350,380,360,-30,-340,-90,350}
- One sub-module, mlp_mac: registered accumulator with load (bias), add-term, and ReLU tap. FSM, counters and argmax tracking live in the top.

## Test plan
- in_data=7'h00, out_ready=1 -> out_valid exactly 51 cycles after acceptance; out_class=4, out_score=425.
- in_data=7'h10 -> out_class=5, out_score=978.
- Exhaustive 128 vectors against a parallel golden model -> class and score match every time, including lowest-index-wins on ties.
- out_ready=0 for 20 cycles in DONE -> out_valid, out_class, out_score held; in_valid ignored (in_ready=0); one result delivered on release.
- rst pulse at cycle 30 of an inference -> all outputs return to reset values immediately. A fresh 7'h00 then yields class 4 after 51 cycles.
- ena toggled low for 5 cycles mid-HID and 3 cycles in DONE -> result unchanged; latency 56 cycles; out_valid low while ena=0.
